// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: FSM states, GF(2^8) constants and helpers.
// Used by mix_word_dual and mix_columns_seq.
package aes_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int STATE_W  = NUM_COLS * COL_W;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] RED_POLY = 8'h1B;

  // First row of each circulant matrix; row r is this row rotated right by r.
  localparam logic [7:0] FWD_COEF [NUM_COLS] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] INV_COEF [NUM_COLS] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; the coefficient is a constant at every call site,
  // so synthesis keeps only the xtime stages and XORs it actually needs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_word_dual.sv
// One-column MixColumns / InvMixColumns. Define MIX_INV_EN to build the inverse
// datapath; without it the mode input is ignored and only the forward path exists.
module mix_word_dual
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             mode,
  output logic [COL_W-1:0] col_out
);

  logic [COL_W-1:0] fwd_out;

  // NOTE: every combinational output gets a default before the loops so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_out = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      for (int k = 0; k < NUM_COLS; k++) begin
        fwd_out[8*r +: 8] ^= gf_mul(col_in[8*k +: 8], FWD_COEF[2'(k - r)]);
      end
    end
  end

`ifdef MIX_INV_EN
  logic [COL_W-1:0] inv_out;

  always_comb begin
    inv_out = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      for (int k = 0; k < NUM_COLS; k++) begin
        inv_out[8*r +: 8] ^= gf_mul(col_in[8*k +: 8], INV_COEF[2'(k - r)]);
      end
    end
  end

  assign col_out = mode ? inv_out : fwd_out;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign col_out     = fwd_out;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle,
// with IDLE/BUSY/DONE handshake FSM. Define MIX_INV_EN to honour in_inv.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic               inv_q, inv_d;
  logic               in_inv_eff;

  logic [COL_W-1:0]   cols_q   [NUM_COLS];
  logic [COL_W-1:0]   cols_upd [NUM_COLS];
  logic [STATE_W-1:0] data_upd;
  logic [1:0]         col_sel  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_in   [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out  [COLS_PER_CYCLE];

`ifdef MIX_INV_EN
  assign in_inv_eff = in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign in_inv_eff    = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) cols_q[i] = data_q[i*COL_W +: COL_W];
  end

  // Columns col_idx .. col_idx+COLS_PER_CYCLE-1 (mod 4) are rewritten in place.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_sel[j] = col_idx_q + 2'(j);
    assign col_in[j]  = cols_q[col_sel[j]];

    mix_word_dual u_mix (
      .col_in  (col_in[j]),
      .mode    (inv_q),
      .col_out (col_out[j])
    );
  end

  always_comb begin
    cols_upd = cols_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) cols_upd[col_sel[j]] = col_out[j];
    data_upd = '0;
    for (int i = 0; i < NUM_COLS; i++) data_upd[i*COL_W +: COL_W] = cols_upd[i];
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    data_d    = data_q;
    inv_d     = inv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          inv_d     = in_inv_eff;
          col_idx_d = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d    = data_upd;
        col_idx_d = col_idx_q + COL_STEP;
        if (col_idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments only, so every flop samples the
  // pre-edge values; the data register is reset too because out_data must
  // read zero after reset and no in-flight result may survive it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_idx_q <= '0;
      data_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      data_q    <= data_d;
      inv_q     <= inv_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench: three DUTs (1, 2 and 4 columns per cycle) against a
// matrix-multiply reference model over GF(2^8).
`timescale 1ns/1ps
module tb_mix_columns_seq;

`ifdef MIX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   in_valid;
  logic [2:0]   in_inv;
  logic [2:0]   out_ready;
  logic [127:0] in_data [3];
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [127:0] out_data [3];

  int checks = 0;
  int errors = 0;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]));

  // ---------------- reference model ----------------
  // Carry-less product followed by polynomial long division by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= int'(a) << i;
    for (int bt = 14; bt >= 8; bt--) if (p[bt]) p ^= 32'h11B << (bt - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    int m [4][4];
    logic [127:0] r;
    logic [7:0] acc;
    if (inv) m = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
    else     m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(s[32*c + 8*k +: 8], 8'(m[row][k]));
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return 4 >> k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on instance k; called and returns at a falling edge.
  task automatic run_txn(input int k, input logic [127:0] d, input bit inv,
                         output logic [127:0] res, output int lat);
    int n;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (in_ready[k] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout inst=%0d in_ready=%b expected 1", k, in_ready[k]);
    end
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_inv[k]   = inv;
    @(negedge clk);
    in_valid[k] = 1'b0;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    lat = n;
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_data[k] !== 128'h0) begin
        errors++;
        $display("FAIL reset inst=%0d in_ready=%b out_valid=%b out_data=%h expected 1/0/0",
                 k, in_ready[k], out_valid[k], out_data[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [127:0] res, d, exp;
    int lat;
    for (int k = 0; k < 3; k++) begin
      d   = {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313DB};
      exp = {32'h01010101, 32'h01010101, 32'h01010101, 32'hBCA14D8E};
      run_txn(k, d, 1'b0, res, lat);
      checks++;
      if (res !== exp || lat !== lat_of(k)) begin
        errors++;
        $display("FAIL kat_col0 inst=%0d got=%h lat=%0d expected=%h lat=%0d", k, res, lat, exp, lat_of(k));
      end
      d   = {4{32'h5C220AF2}};
      exp = {4{32'h9D58DC9F}};
      run_txn(k, d, 1'b0, res, lat);
      checks++;
      if (res !== exp || lat !== lat_of(k)) begin
        errors++;
        $display("FAIL kat_all inst=%0d got=%h lat=%0d expected=%h lat=%0d", k, res, lat, exp, lat_of(k));
      end
      // With the inverse compiled in this is InvMixColumns; otherwise in_inv is ignored.
      d   = {4{32'hBCA14D8E}};
      exp = INV_EN ? {4{32'h455313DB}} : model(d, 1'b0);
      run_txn(k, d, 1'b1, res, lat);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL kat_inv_mode inst=%0d got=%h expected=%h", k, res, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] d, res, res2, exp;
    bit inv;
    int lat;
    for (int k = 0; k < 3; k++) begin
      for (int it = 0; it < 4; it++) begin
        d   = rand128();
        inv = 1'($urandom);
        exp = model(d, inv && INV_EN);
        run_txn(k, d, inv, res, lat);
        checks++;
        if (res !== exp) begin
          errors++;
          $display("FAIL random inst=%0d in=%h inv=%0d got=%h expected=%h", k, d, inv, res, exp);
        end
        if (INV_EN) begin
          run_txn(k, model(d, 1'b0), 1'b1, res2, lat);
          checks++;
          if (res2 !== d) begin
            errors++;
            $display("FAIL roundtrip inst=%0d got=%h expected=%h", k, res2, d);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] d, exp, res;
    int n, lat;
    bit bad;
    // out_ready pulses while idle must do nothing.
    out_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_out_ready in_ready=%b out_valid=%b expected 1/0", in_ready[0], out_valid[0]);
    end
    d   = rand128();
    exp = model(d, 1'b0);
    in_valid[0] = 1'b1; in_data[0] = d; in_inv[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid[0] = 1'b1; in_data[0] = rand128(); end
      if (c == 6) in_valid[0] = 1'b0;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== exp) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold out_valid=%b in_ready=%b out_data=%h expected 1/0/%h",
               out_valid[0], in_ready[0], out_data[0], exp);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release in_ready=%b out_valid=%b expected 1/0", in_ready[0], out_valid[0]);
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ignored_capture out_valid=%b in_ready=%b expected 0/1", out_valid[0], in_ready[0]);
    end
    // Normal operation resumes afterwards.
    d = rand128();
    run_txn(0, d, 1'b0, res, lat);
    checks++;
    if (res !== model(d, 1'b0)) begin
      errors++;
      $display("FAIL after_stall got=%h expected=%h", res, model(d, 1'b0));
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    in_valid[0] = 1'b1; in_data[0] = rand128(); in_inv[0] = 1'b0;
    in_valid[2] = 1'b1; in_data[2] = rand128(); in_inv[2] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0; in_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid[2] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_state c4_valid=%b c1_valid=%b expected 1/0", out_valid[2], out_valid[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k += 2) begin
      checks++;
      if (out_valid[k] !== 1'b0 || out_data[k] !== 128'h0 || in_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL midflight_reset inst=%0d out_valid=%b out_data=%h in_ready=%b expected 0/0/1",
                 k, out_valid[k], out_data[k], in_ready[k]);
      end
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 3'b000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stale_result out_valid=%b expected 000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    int times [$];
    logic [127:0] d, exp;
    int n;
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      times.delete();
      out_ready[k] = 1'b1;
      in_inv[k]    = 1'b0;
      for (int t = 0; t < 3 * (lat_of(k) + 2) + 4; t++) begin
        if (out_valid[k] === 1'b1) begin
          times.push_back(t);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
          checks++;
          if (out_data[k] !== exp) begin
            errors++;
            $display("FAIL b2b_data inst=%0d got=%h expected=%h", k, out_data[k], exp);
          end
        end
        if (in_ready[k] === 1'b1) begin
          d = rand128();
          in_data[k]  = d;
          in_valid[k] = 1'b1;
          exp_q.push_back(model(d, 1'b0));
        end
        @(negedge clk);
      end
      in_valid[k] = 1'b0;
      checks++;
      if (times.size() < 3) begin
        errors++;
        $display("FAIL b2b_count inst=%0d results=%0d expected>=3", k, times.size());
      end else if (times[1] - times[0] != lat_of(k) + 2 || times[2] - times[1] != lat_of(k) + 2) begin
        errors++;
        $display("FAIL b2b_period inst=%0d spacing=%0d,%0d expected %0d", k,
                 times[1] - times[0], times[2] - times[1], lat_of(k) + 2);
      end
      n = 0;
      while (in_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      out_ready[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    in_valid  = '0;
    in_inv    = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_random();
    test_stall();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
- REQ-001: Parameter COLS_PER_CYCLE, default 1, number of 32-bit columns transformed per cycle; legal values 1, 2, 4.
- REQ-002: Port clk, input, 1, single clock; all state updates on its rising edge.
- REQ-003: Port rst_n, input, 1, reset, synchronous and active-low.
- REQ-004: Port in_valid, input, 1, high when in_data/in_inv carry a state to transform.
- REQ-005: Port in_ready, output, 1, high when the block accepts a state this cycle.
- REQ-006: Port in_data, input, 128, AES state; column c = in_data[32c+31:32c], row r of that column = bits [32c+8r+7:32c+8r].
- REQ-007: Port in_inv, input, 1, 0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
- REQ-008: Port out_valid, output, 1, high while out_data holds a finished result.
- REQ-009: Port out_ready, input, 1, consumer accepts the result.
- REQ-010: Port out_data, output, 128, transformed state, same column/row layout as in_data.

Function
- REQ-011: The FSM SHALL have states IDLE, BUSY and DONE.
- REQ-012: in_ready SHALL equal (state == IDLE).
- REQ-013: In IDLE, in_valid=1 SHALL capture in_data and in_inv, clear column counter col_idx to 0, and go to BUSY.
- REQ-014: In BUSY, each cycle SHALL transform columns col_idx .. col_idx+COLS_PER_CYCLE-1 in place and advance col_idx by COLS_PER_CYCLE, modulo 4.
- REQ-015: BUSY SHALL last exactly 4/COLS_PER_CYCLE cycles and then go to DONE; out_valid rises 4/COLS_PER_CYCLE cycles after the accept edge.
- REQ-016: Forward transform per column (a0..a3 = rows 0..3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, in GF(2^8) mod 0x11B.
- REQ-017: Inverse transform SHALL use coefficients {0e,0b,0d,09} in the same circulant arrangement.
- REQ-018: All GF products SHALL be reduced to exactly 8 bits; no carry beyond bit 7 may reach any output byte.
- REQ-019: In DONE, out_valid=1 and out_data SHALL stay stable until out_ready=1; on that edge go to IDLE.
- REQ-020: in_valid during BUSY or DONE SHALL be ignored, with no capture and no state change.
- REQ-021: out_ready while out_valid=0 SHALL have no effect.
- REQ-022: Throughput SHALL be one state per 4/COLS_PER_CYCLE+2 cycles when out_ready is held high.

Reset
- REQ-023: rst_n=0 at a clock edge SHALL force IDLE, col_idx=0, out_valid=0, out_data=0 and clear the captured mode, in any state.
- REQ-024: Reset during BUSY or DONE SHALL discard the in-flight state; no out_valid may follow from it.

Configuration
- REQ-025: Macro MIX_INV_EN defined SHALL compile in the inverse datapath and honour in_inv.
- REQ-026: Macro MIX_INV_EN undefined SHALL remove the inverse datapath, ignore in_inv, and always apply the forward transform.

Structure
- REQ-027: Package aes_pkg SHALL hold the FSM state enum, the xtime/GF-multiply constants (reduction polynomial 0x1B), and the column-width constant 32.
- REQ-028: Sub-module mix_word_dual SHALL transform one 32-bit column with a mode input; mix_columns_seq SHALL instantiate COLS_PER_CYCLE copies.

Verification
- REQ-029: Forward, column 0 = 0x455313DB, other columns 0x01010101 -> out column 0 = 0xBCA14D8E, others 0x01010101.
- REQ-030: Forward, all columns 0x5C220AF2 -> all columns 0x9D58DC9F; out_valid 4/COLS_PER_CYCLE cycles after accept.
- REQ-031: Inverse (MIX_INV_EN), all columns 0xBCA14D8E -> all columns 0x455313DB; forward then inverse of random data is the identity.
- REQ-032: out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0, a second in_valid is ignored; after out_ready=1, IDLE and in_ready=1.
- REQ-033: rst_n=0 mid-BUSY -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result ever appears.
- REQ-034: Repeat REQ-029 and REQ-030 with COLS_PER_CYCLE = 1, 2 and 4 -> identical data, with latencies 4, 2 and 1 respectively.
